// File: rtl/gmii_rx_writer.sv
// rtl/gmii_rx_writer.sv - GMII receive framer writing frames into a circular packet buffer
//
// Strips preamble/SFD, packs bytes into 16-bit words ({odd, even}) and writes
// each frame behind a length header into a 4096-word ring. rxmem_wr_ptr only
// moves once the whole frame and its header are in memory; dropped frames
// (no room, oversize, runt) leave it untouched.
//
// Optional feature macro: RX_TIMESTAMP_EN adds ts_counter and four timestamp
// header words (LS word first) after the length word.
//
// Ports:
//   gmii_rx_clk    in   125 MHz receive clock (only clock)
//   sys_rst_n      in   asynchronous active-low reset
//   gmii_rx_dv     in   GMII receive data valid
//   gmii_rxd       in   GMII receive byte
//   rxmem_rd_ptr   in   consumer read pointer (word address)
//   ts_counter     in   free-running timestamp (RX_TIMESTAMP_EN only)
//   rxmem_wr_en    out  buffer write strobe
//   rxmem_wr_addr  out  buffer write word address
//   rxmem_wr_data  out  buffer write data
//   rxmem_wr_ptr   out  committed write pointer (first free word)
//   rx_frame_cnt   out  committed frame count (wraps)
//   rx_drop_cnt    out  dropped frame count (wraps)

module gmii_rx_writer #(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic [11:0] rxmem_rd_ptr,
`ifdef RX_TIMESTAMP_EN
  input  logic [63:0] ts_counter,
`endif
  output logic        rxmem_wr_en,
  output logic [11:0] rxmem_wr_addr,
  output logic [15:0] rxmem_wr_data,
  output logic [11:0] rxmem_wr_ptr,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_drop_cnt
);

`ifdef RX_TIMESTAMP_EN
  localparam int HDR = 5;
`else
  localparam int HDR = 1;
`endif
  localparam logic [11:0] HDR_W    = 12'(HDR);
  localparam logic [2:0]  HDR_LAST = 3'(HDR - 1);
  localparam logic [11:0] MAX_W    = 12'(MAX_FRAME);
  localparam logic [11:0] MIN_W    = 12'(MIN_FRAME);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_DATA, S_FLUSH, S_COMMIT, S_DROP_WAIT
  } state_t;

  state_t      state;
  logic [11:0] start_ptr;
  logic [11:0] data_addr;
  logic [11:0] byte_cnt;
  logic [7:0]  even_byte;
  logic [2:0]  hdr_idx;
  logic        commit_pend;
`ifdef RX_TIMESTAMP_EN
  logic [63:0] ts_latch;
`endif

  logic [11:0] free_words;
  logic [11:0] cnt_inc;
  logic        addr_ok;
  logic [15:0] hdr_word;

  // rd_ptr is used live, so a consumer advance frees space immediately.
  assign free_words = rxmem_rd_ptr - rxmem_wr_ptr - 12'd1;
  assign addr_ok    = (data_addr + 12'd1) != rxmem_rd_ptr;
  assign cnt_inc    = byte_cnt + 12'd1;

  always_comb begin
    hdr_word = {4'd0, byte_cnt};
`ifdef RX_TIMESTAMP_EN
    case (hdr_idx)
      3'd1:    hdr_word = ts_latch[15:0];
      3'd2:    hdr_word = ts_latch[31:16];
      3'd3:    hdr_word = ts_latch[47:32];
      3'd4:    hdr_word = ts_latch[63:48];
      default: hdr_word = {4'd0, byte_cnt};
    endcase
`endif
  end

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      start_ptr     <= '0;
      data_addr     <= '0;
      byte_cnt      <= '0;
      even_byte     <= '0;
      hdr_idx       <= '0;
      commit_pend   <= 1'b0;
      rxmem_wr_en   <= 1'b0;
      rxmem_wr_addr <= '0;
      rxmem_wr_data <= '0;
      rxmem_wr_ptr  <= '0;
      rx_frame_cnt  <= '0;
      rx_drop_cnt   <= '0;
`ifdef RX_TIMESTAMP_EN
      ts_latch      <= '0;
`endif
    end else begin
      rxmem_wr_en <= 1'b0;
      commit_pend <= 1'b0;

      // Pointer moves the cycle after the last header write is presented,
      // so the header is in memory before the host can see the frame.
      if (commit_pend) begin
        rxmem_wr_ptr <= data_addr;
        rx_frame_cnt <= rx_frame_cnt + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (gmii_rx_dv)
            state <= (gmii_rxd == 8'h55) ? S_PREAMBLE : S_DROP_WAIT;
        end

        S_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            if (free_words < HDR_W + 12'd1) begin
              state       <= S_DROP_WAIT;
              rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end else begin
              state     <= S_DATA;
              start_ptr <= rxmem_wr_ptr;
              data_addr <= rxmem_wr_ptr + HDR_W;
              byte_cnt  <= '0;
`ifdef RX_TIMESTAMP_EN
              ts_latch  <= ts_counter;
`endif
            end
          end else if (gmii_rxd != 8'h55) begin
            state <= S_DROP_WAIT;
          end
        end

        S_DATA: begin
          if (gmii_rx_dv) begin
            if (cnt_inc > MAX_W) begin
              state       <= S_DROP_WAIT;
              rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end else if (!byte_cnt[0]) begin
              even_byte <= gmii_rxd;
              byte_cnt  <= cnt_inc;
            end else if (!addr_ok) begin
              // Writing here would make the ring look empty to the consumer.
              state       <= S_DROP_WAIT;
              rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end else begin
              rxmem_wr_en   <= 1'b1;
              rxmem_wr_addr <= data_addr;
              rxmem_wr_data <= {gmii_rxd, even_byte};
              data_addr     <= data_addr + 12'd1;
              byte_cnt      <= cnt_inc;
            end
          end else if (byte_cnt < MIN_W) begin
            state       <= S_IDLE;
            rx_drop_cnt <= rx_drop_cnt + 16'd1;
          end else if (byte_cnt[0]) begin
            state <= S_FLUSH;
          end else begin
            state   <= S_COMMIT;
            hdr_idx <= '0;
          end
        end

        S_FLUSH: begin
          if (addr_ok) begin
            rxmem_wr_en   <= 1'b1;
            rxmem_wr_addr <= data_addr;
            rxmem_wr_data <= {8'h00, even_byte};
            data_addr     <= data_addr + 12'd1;
            state         <= S_COMMIT;
            hdr_idx       <= '0;
          end else begin
            state       <= S_IDLE;
            rx_drop_cnt <= rx_drop_cnt + 16'd1;
          end
        end

        S_COMMIT: begin
          // Header space was reserved at SFD, so no legality check here.
          rxmem_wr_en   <= 1'b1;
          rxmem_wr_addr <= start_ptr + 12'(hdr_idx);
          rxmem_wr_data <= hdr_word;
          if (hdr_idx == HDR_LAST) begin
            state       <= S_IDLE;
            commit_pend <= 1'b1;
          end else begin
            hdr_idx <= hdr_idx + 3'd1;
          end
        end

        S_DROP_WAIT: begin
          if (!gmii_rx_dv)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gmii_rx_writer.md
# gmii_rx_writer

Receive-side stage between the PHY GMII receive interface and the PCIe-visible receive packet memory. It strips preamble and SFD from each GMII frame and packs the bytes into 16-bit words. It writes each frame into a 4096-word circular buffer behind a length header. A frame becomes visible to the host consumer only when it completes, through a committed write pointer; frames that do not fit, are oversized or are runts are discarded without disturbing the pointer.

## Interface
- MAX_FRAME, 1518: largest accepted frame in bytes, FCS included.
- MIN_FRAME, 64: smallest accepted frame in bytes.
- gmii_rx_clk  input  1  125 MHz receive clock; the only clock.
- sys_rst_n  input  1  reset, asynchronous, active-low.
- gmii_rx_dv  input  1  GMII receive data valid.
- gmii_rxd  input  8  GMII receive byte.
- rxmem_rd_ptr  input  12  consumer read pointer, word address.
- ts_counter  input  64  free-running timestamp; present only with RX_TIMESTAMP_EN.
- rxmem_wr_en  output  1  buffer write strobe.
- rxmem_wr_addr  output  12  buffer write word address.
- rxmem_wr_data  output  16  buffer write data.
- rxmem_wr_ptr  output  12  committed write pointer; first free word.
- rx_frame_cnt  output  16  committed frames; wraps.
- rx_drop_cnt  output  16  dropped frames (overflow, oversize, runt); wraps.

## Operation
- HDR = 1 word without RX_TIMESTAMP_EN, 5 words with it.
- Buffer layout per frame, starting at the committed pointer S:
  - S holds the byte length in 16 bits, FCS included.
  - Timestamp words follow the length word (macro only).
  - Data words start at S+HDR. Each word is {odd byte, even byte}, first byte in [7:0].
  - The final odd byte is padded: {8'h00, byte}.
- Next frame starts at S + HDR + ceil(len/2), mod 4096.
- Empty condition: rxmem_wr_ptr == rxmem_rd_ptr. Free words = (rd_ptr − wr_ptr − 1) mod 4096.
- A write to address a is legal only if (a+1) mod 4096 != rxmem_rd_ptr.

State machine:
- IDLE
  - dv=1 and rxd=0x55 → PREAMBLE.
  - dv=1 with any other byte → DROP_WAIT, no count.
- PREAMBLE
  - rxd=0x55: stay.
  - dv=1 and rxd=0xD5 (SFD) → DATA. On the SFD cycle: latch S = rxmem_wr_ptr, set the data address to S+HDR, clear the byte count, latch the timestamp.
  - If free words < HDR+1 at SFD: go to DROP_WAIT instead and increment rx_drop_cnt.
  - Any other byte → DROP_WAIT, no count.
  - dv=0 → IDLE, no count.
- DATA, on each byte with dv=1:
  - Increment the byte count.
  - Even-index byte: held in a register.
  - Odd-index byte: the word is written, then the data address increments.
  - If the write address is illegal → DROP_WAIT and increment rx_drop_cnt; the word is not written.
  - If the byte count would exceed MAX_FRAME → DROP_WAIT and increment rx_drop_cnt.
- DATA, when dv falls:
  - If count < MIN_FRAME → IDLE and increment rx_drop_cnt.
  - Else if count is odd → FLUSH (pad word; the same legality check applies, failing → IDLE and increment rx_drop_cnt).
  - Else → COMMIT.
- COMMIT
  - Writes the length word at S, then the timestamp words at S+1..S+4 with the least-significant word first (macro only). One word per cycle.
  - After the final write, rxmem_wr_ptr ← data address and rx_frame_cnt increments → IDLE.
- DROP_WAIT: wait for dv=0 → IDLE. rxmem_wr_ptr never moves on a drop.
- Bytes arriving during FLUSH or COMMIT are ignored. The 12-byte minimum IPG plus 7-byte preamble guarantees re-synchronisation.
- Address arithmetic is 12-bit modulo; wrap from 4095 to 0 is seamless inside a frame and inside the header.

## Timing
- Reset: all outputs 0, state IDLE; asynchronous assertion, synchronous to the clock on release.
- Reset mid-frame discards the frame; counters and pointer return to 0.
- All outputs are registered.
- Data word write: rxmem_wr_en is high the cycle after the odd byte is sampled. At most one write per cycle.
- FLUSH: 1 cycle. COMMIT: HDR cycles.
- rxmem_wr_ptr updates 1 cycle after the last COMMIT write, so the length word is always in memory before the pointer exposes it.
- rxmem_rd_ptr is sampled every cycle; a pointer advance during a frame enlarges the free space immediately.

## Configuration
- RX_TIMESTAMP_EN defined: ts_counter port exists, HDR=5, and the SFD-cycle timestamp is stored after the length word.
- RX_TIMESTAMP_EN undefined: no ts_counter port, HDR=1, COMMIT lasts 1 cycle.

## Test plan
- Reset, rd_ptr=0, one 64-byte frame (7×0x55, 0xD5, bytes 0x00..0x3F) → addr0 = 0x0040, addr1 = 0x0100, addr32 = 0x3F3E, wr_ptr = 33 (37 with macro), rx_frame_cnt = 1.
- 65-byte frame following → last word {0x00, 0x40} written, length word 0x0041, wr_ptr advances by 34 (38 with macro).
- rd_ptr = 20, 64-byte frame from wr_ptr 0 → write stops before address 19, wr_ptr stays 0, rx_drop_cnt = 1; the next frame after rd_ptr = 0 commits normally.
- 1519-byte frame → dropped, rx_drop_cnt +1; 60-byte frame → dropped, rx_drop_cnt +1, wr_ptr unchanged in both cases.
- wr_ptr = 4090, rd_ptr = 100, 64-byte frame → length word at 4090, data wraps through 0, wr_ptr = 27 (31 with macro).
- sys_rst_n pulsed low mid-DATA → all outputs 0 immediately; the following clean frame commits at address 0.
